// File: rtl/vga_timing_if.sv
// ---------------------------------------------------------------------------
// vga_timing_if
//   Bundle between the VGA raster/pattern generator and its consumer
//   (board DAC pins or a checker).
//
//   mode         pattern select into the generator
//   hsync/vsync  sync pulses
//   pxlClk       one-clk pixel enable
//   hcount/vcount raster position of the current output pixel
//   active       current pixel is visible
//   frame_start  pulse on pixel (0,0)
//   red/green/blue colour channels
//
//   master: the generator side; slave: the consumer side.
// ---------------------------------------------------------------------------
interface vga_timing_if #(
    parameter int CNT_W   = 11,
    parameter int COLOR_W = 4
);
    logic [1:0]         mode;
    logic               hsync;
    logic               vsync;
    logic               pxlClk;
    logic [CNT_W-1:0]   hcount;
    logic [CNT_W-1:0]   vcount;
    logic               active;
    logic               frame_start;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;

    modport master (
        input  mode,
        output hsync, vsync, pxlClk, hcount, vcount, active, frame_start,
        output red, green, blue
    );

    modport slave (
        output mode,
        input  hsync, vsync, pxlClk, hcount, vcount, active, frame_start,
        input  red, green, blue
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   VGA raster timing generator with a frame-synchronised test-pattern
//   source. A clock divider produces a one-clk pixel enable (pxlClk); on each
//   enable the internal column/row counters advance and a one-pixel output
//   register loads sync, position, visibility and colour for the pre-advance
//   position, so every output is mutually aligned.
//
//   Ports:
//     clk   system clock
//     rst   synchronous reset, active-low
//     vga   vga_timing_if.master: mode in; hsync, vsync, pxlClk, hcount,
//           vcount, active, frame_start, red, green, blue out
//
//   Optional feature (macro VGA_BORDER_EN): when defined, the outermost ring
//   of visible pixels is forced to pure red, overriding the selected pattern.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_ACTIVE  = 800,
    parameter int H_FP      = 56,
    parameter int H_SYNC    = 120,
    parameter int H_BP      = 64,
    parameter int V_ACTIVE  = 600,
    parameter int V_FP      = 37,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 23,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1,
    parameter int COLOR_W   = 4,
    parameter int CNT_W     = 11
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int LVL_MAX = (1 << COLOR_W) - 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             HS_ON      = 1'(HSYNC_POL);
    localparam logic             VS_ON      = 1'(VSYNC_POL);

    // Bad parameter sets are rejected at elaboration; the checkerboard needs
    // bit 5 of the counters and the bars need at least one pixel per bar.
    generate
        if (CLK_DIV < 1 || H_ACTIVE < 8 || V_ACTIVE < 1 || CNT_W < 6 ||
            H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W) ||
            COLOR_W < 1) begin : g_bad_params
            $error("vga_timing_gen: invalid parameter set");
        end
    endgenerate

    // Clamp a computed intensity to the channel range.
    function automatic logic [COLOR_W-1:0] sat_level(input int x);
        if (x > LVL_MAX) return {COLOR_W{1'b1}};
        else             return COLOR_W'(x);
    endfunction

    // Colour of a visible pixel for a given pattern, packed {r,g,b}.
    function automatic logic [3*COLOR_W-1:0] pattern_rgb(
        input logic [CNT_W-1:0] h,
        input logic [CNT_W-1:0] v,
        input logic [1:0]       m
    );
        logic [2:0]         bar;
        logic [COLOR_W-1:0] lvl;
        int                 idx;
        pattern_rgb = '0;
        bar         = 3'b000;
        lvl         = '0;
        idx         = 0;
        case (m)
            2'd0: begin
                // The last bar also takes the H_ACTIVE % 8 leftover pixels.
                idx = int'(h) / BAR_W;
                if (idx > 7) idx = 7;
                case (idx)
                    0:       bar = 3'b111;  // white
                    1:       bar = 3'b110;  // yellow
                    2:       bar = 3'b011;  // cyan
                    3:       bar = 3'b010;  // green
                    4:       bar = 3'b101;  // magenta
                    5:       bar = 3'b100;  // red
                    6:       bar = 3'b001;  // blue
                    default: bar = 3'b000;  // black
                endcase
                pattern_rgb = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}},
                               {COLOR_W{bar[0]}}};
            end
            2'd1: begin
                pattern_rgb = (h[5] ^ v[5]) ? {3*COLOR_W{1'b1}} : '0;
            end
            2'd2: begin
                lvl         = sat_level((int'(h) << COLOR_W) / H_ACTIVE);
                pattern_rgb = {lvl, lvl, lvl};
            end
            default: begin
                pattern_rgb = {3*COLOR_W{1'b1}};
            end
        endcase
    endfunction

    logic [DIV_W-1:0]   div_q, div_d;
    logic               pxl_q, pxl_d;
    logic [CNT_W-1:0]   h_q, h_d;
    logic [CNT_W-1:0]   v_q, v_d;
    logic [1:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   hcount_q, hcount_d;
    logic [CNT_W-1:0]   vcount_q, vcount_d;
    logic               active_q, active_d;
    logic               fs_q, fs_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic [COLOR_W-1:0] red_q, red_d;
    logic [COLOR_W-1:0] green_q, green_d;
    logic [COLOR_W-1:0] blue_q, blue_d;

    logic               at_origin;
    logic               vis;
    logic [1:0]         mode_eff;
    logic [3*COLOR_W-1:0] rgb;

    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        pxl_d    = (div_q == DIV_LAST);
        h_d      = h_q;
        v_d      = v_q;
        mode_d   = mode_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        active_d = active_q;
        fs_d     = fs_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        red_d    = red_q;
        green_d  = green_q;
        blue_d   = blue_q;

        at_origin = (h_q == '0) && (v_q == '0);
        vis       = (h_q < H_ACT_C) && (v_q < V_ACT_C);
        // The frame's first pixel already uses the newly sampled mode, so a
        // whole frame is always drawn with one pattern.
        mode_eff  = at_origin ? vga.mode : mode_q;

        rgb = '0;
        if (vis) begin
            rgb = pattern_rgb(h_q, v_q, mode_eff);
`ifdef VGA_BORDER_EN
            if (h_q == '0 || h_q == H_ACT_LAST || v_q == '0 || v_q == V_ACT_LAST)
                rgb = {{COLOR_W{1'b1}}, {2*COLOR_W{1'b0}}};
`endif
        end

        if (pxl_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end

            if (at_origin) mode_d = vga.mode;

            hcount_d = h_q;
            vcount_d = v_q;
            active_d = vis;
            fs_d     = at_origin;
            hsync_d  = (h_q >= HS_START && h_q < HS_END) ? HS_ON : ~HS_ON;
            vsync_d  = (v_q >= VS_START && v_q < VS_END) ? VS_ON : ~VS_ON;
            red_d    = rgb[3*COLOR_W-1 -: COLOR_W];
            green_d  = rgb[2*COLOR_W-1 -: COLOR_W];
            blue_d   = rgb[COLOR_W-1   -: COLOR_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q    <= '0;
            pxl_q    <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
            mode_q   <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
            active_q <= 1'b0;
            fs_q     <= 1'b0;
            hsync_q  <= ~HS_ON;
            vsync_q  <= ~VS_ON;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
        end else begin
            div_q    <= div_d;
            pxl_q    <= pxl_d;
            h_q      <= h_d;
            v_q      <= v_d;
            mode_q   <= mode_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            active_q <= active_d;
            fs_q     <= fs_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
        end
    end

    assign vga.pxlClk      = pxl_q;
    assign vga.hcount      = hcount_q;
    assign vga.vcount      = vcount_q;
    assign vga.active      = active_q;
    assign vga.frame_start = fs_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.red         = red_q;
    assign vga.green       = green_q;
    assign vga.blue        = blue_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Bench for vga_timing_gen with a reduced raster (40x20 visible, 56x28
//   total, CLK_DIV=2) so several whole frames fit in a short run. Every clock
//   the outputs are compared against a reference that derives the raster
//   position from the number of pixel enables since reset. A vector table
//   checks captured pattern pixels, and hand sequences cover sync timing,
//   mid-frame mode switching and mid-frame reset.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_gen;
    localparam int D  = 2;
    localparam int HA = 40, HF = 4, HS = 6, HB = 6;
    localparam int VA = 20, VF = 2, VS = 3, VB = 3;
    localparam int HSP = 1, VSP = 1;
    localparam int CW = 4, NW = 11;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_timing_if #(.CNT_W(NW), .COLOR_W(CW)) vif();

    vga_timing_gen #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(HSP), .VSYNC_POL(VSP), .COLOR_W(CW), .CNT_W(NW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vga(vif)
    );

    typedef struct {
        int          m;
        int          h;
        int          v;
        logic [11:0] rgb;
    } vec_t;

    int n_pass = 0;
    int n_tot  = 0;

    int   j = 0, e_prev = 0, frame_mode = 0, cyc = 0;
    int   ph = 0, pv = 0;
    logic new_pix = 1'b0;
    logic [3*CW-1:0] cap [HT][VT];

    int   last_hrise = 0, last_vrise = 0;
    int   hfall[$], vfall[$], hhigh[$], vhigh[$];
    logic prev_hs = 1'b0, prev_vs = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference colour for visible pixel (h,v) in pattern m, packed {r,g,b}.
    function automatic logic [3*CW-1:0] ref_rgb(input int h, input int v,
                                                 input int m);
        logic [2:0] bars [8];
        int b, g;
        bars = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        if (!(h < HA && v < VA)) return '0;
`ifdef VGA_BORDER_EN
        if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1)
            return {{CW{1'b1}}, {2*CW{1'b0}}};
`endif
        case (m)
            0: begin
                b = h / (HA / 8);
                if (b > 7) b = 7;
                return {{CW{bars[b][2]}}, {CW{bars[b][1]}}, {CW{bars[b][0]}}};
            end
            1: return (((h / 32) % 2) != ((v / 32) % 2)) ? '1 : '0;
            2: begin
                g = h * (1 << CW) / HA;
                if (g > (1 << CW) - 1) g = (1 << CW) - 1;
                return {3{CW'(g)}};
            end
            default: return '1;
        endcase
    endfunction

    // One clock: advance the reference at the posedge, compare at the negedge.
    task automatic step();
        logic        rs;
        logic [1:0]  md;
        int          e;
        logic [63:0] exp_v, act_v;
        logic        ex_hs, ex_vs;
        @(posedge clk);
        rs = rst;
        md = vif.mode;
        new_pix = 1'b0;
        if (!rs) begin
            j = 0;
            e_prev = 0;
        end else begin
            j++;
            e = (j - 1) / D;
            if (e != e_prev) begin
                new_pix = 1'b1;
                ph = (e - 1) % HT;
                pv = ((e - 1) / HT) % VT;
                if ((e - 1) % FR == 0) frame_mode = int'(md);
                e_prev = e;
            end
        end
        @(negedge clk);
        cyc++;

        if (j == 0 || e_prev == 0) begin
            exp_v = 64'({1'b0, 1'(!HSP), 1'(!VSP), 1'b0, 1'b0,
                         NW'(0), NW'(0), 12'h000});
            if (j > 0) exp_v[38] = (j % D == 0);
        end else begin
            ex_hs = (ph >= HA + HF && ph < HA + HF + HS) ? 1'(HSP) : 1'(!HSP);
            ex_vs = (pv >= VA + VF && pv < VA + VF + VS) ? 1'(VSP) : 1'(!VSP);
            exp_v = 64'({1'(j % D == 0), ex_hs, ex_vs,
                         1'(ph < HA && pv < VA), 1'(ph == 0 && pv == 0),
                         NW'(ph), NW'(pv), ref_rgb(ph, pv, frame_mode)});
        end
        act_v = 64'({vif.pxlClk, vif.hsync, vif.vsync, vif.active,
                     vif.frame_start, vif.hcount, vif.vcount,
                     vif.red, vif.green, vif.blue});
        check($sformatf("out@cyc%0d", cyc), act_v, exp_v);

        if (new_pix) cap[ph][pv] = {vif.red, vif.green, vif.blue};

        if (vif.hsync && !prev_hs) last_hrise = cyc;
        if (!vif.hsync && prev_hs) begin
            hfall.push_back(cyc);
            hhigh.push_back(cyc - last_hrise);
        end
        if (vif.vsync && !prev_vs) last_vrise = cyc;
        if (!vif.vsync && prev_vs) begin
            vfall.push_back(cyc);
            vhigh.push_back(cyc - last_vrise);
        end
        prev_hs = vif.hsync;
        prev_vs = vif.vsync;
    endtask

    // Step until the reference loads pixel (h,v); bounded by one frame.
    task automatic wait_pix(input int h, input int v, input string name);
        int k = 0;
        do begin
            step();
            k++;
        end while (!(new_pix && ph == h && pv == v) && k < FR * D + 50);
        n_tot++;
        if (new_pix && ph == h && pv == v) n_pass++;
        else $display("FAIL %s: pixel (%0d,%0d) not reached in %0d clks", name, h, v, k);
    endtask

    initial begin
        vec_t tbl[$];
        int   k;

        tbl.push_back('{0,  2, 5, 12'hFFF});
        tbl.push_back('{0,  7, 5, 12'hFF0});
        tbl.push_back('{0, 12, 5, 12'h0FF});
        tbl.push_back('{0, 17, 5, 12'h0F0});
        tbl.push_back('{0, 22, 5, 12'hF0F});
        tbl.push_back('{0, 27, 5, 12'hF00});
        tbl.push_back('{0, 32, 5, 12'h00F});
        tbl.push_back('{0, 37, 5, 12'h000});
        tbl.push_back('{0, 45, 5, 12'h000});
        tbl.push_back('{1,  5, 3, 12'h000});
        tbl.push_back('{1, 33, 3, 12'hFFF});
        tbl.push_back('{1, 33, 22, 12'h000});
        tbl.push_back('{2,  3, 4, 12'h111});
        tbl.push_back('{2, 20, 4, 12'h888});
        tbl.push_back('{2, 38, 4, 12'hFFF});
        tbl.push_back('{3,  5, 5, 12'hFFF});
        tbl.push_back('{3,  5, 24, 12'h000});
`ifdef VGA_BORDER_EN
        tbl.push_back('{3,  0, 5, 12'hF00});
        tbl.push_back('{3, 39, 5, 12'hF00});
        tbl.push_back('{3,  5, 0, 12'hF00});
        tbl.push_back('{3,  5, 19, 12'hF00});
`else
        tbl.push_back('{3,  0, 5, 12'hFFF});
        tbl.push_back('{3, 39, 5, 12'hFFF});
        tbl.push_back('{3,  5, 0, 12'hFFF});
        tbl.push_back('{3,  5, 19, 12'hFFF});
`endif

        // Reset state.
        vif.mode = 2'd0;
        rst = 1'b0;
        repeat (3) step();
        check("rst_pxlclk", 64'(vif.pxlClk), 64'(0));
        check("rst_hsync",  64'(vif.hsync),  64'(!HSP));
        check("rst_vsync",  64'(vif.vsync),  64'(!VSP));
        check("rst_rgb",    64'({vif.red, vif.green, vif.blue}), 64'(0));

        // Sync timing over two frames.
        rst = 1'b1;
        hfall.delete(); vfall.delete(); hhigh.delete(); vhigh.delete();
        repeat (2 * FR * D + 300) step();
        if (vfall.size() >= 2 && hfall.size() >= 2) begin
            check("vsync_period", 64'(vfall[1] - vfall[0]), 64'(FR * D));
            check("vsync_high",   64'(vhigh[1]), 64'(VS * HT * D));
            check("hsync_period", 64'(hfall[1] - hfall[0]), 64'(HT * D));
            check("hsync_high",   64'(hhigh[1]), 64'(HS * D));
        end else begin
            check("sync_edges_seen", 64'(vfall.size()), 64'(2));
        end

        // One full frame per pattern, then table lookup.
        for (int m = 0; m < 4; m++) begin
            vif.mode = 2'(m);
            wait_pix(0, 0, $sformatf("frame_start_m%0d", m));
            wait_pix(HT - 1, VT - 1, $sformatf("frame_end_m%0d", m));
            foreach (tbl[i]) begin
                if (tbl[i].m == m)
                    check($sformatf("tbl_m%0d_(%0d,%0d)", m, tbl[i].h, tbl[i].v),
                          64'(cap[tbl[i].h][tbl[i].v]), 64'(tbl[i].rgb));
            end
        end

        // Mode change mid-frame waits for the next frame.
        vif.mode = 2'd0;
        wait_pix(0, 0, "sw_frame_start");
        wait_pix(0, 10, "sw_line10");
        vif.mode = 2'd3;
        wait_pix(HT - 1, VT - 1, "sw_frame_end");
        check("sw_same_frame_bars", 64'(cap[7][15]), 64'(12'hFF0));
        wait_pix(10, 1, "sw_next_frame");
        check("sw_next_frame_white", 64'(cap[7][1]), 64'(12'hFFF));

        // Reset in the middle of a frame.
        wait_pix(30, 12, "mid_rst_pos");
        rst = 1'b0;
        step();
        check("mid_rst_hsync", 64'(vif.hsync), 64'(!HSP));
        check("mid_rst_vsync", 64'(vif.vsync), 64'(!VSP));
        check("mid_rst_rgb",   64'({vif.red, vif.green, vif.blue}), 64'(0));
        repeat (2) step();
        rst = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while (!new_pix && k < 10);
        check("post_rst_first_pix", 64'(new_pix), 64'(1));
        check("post_rst_hcount", 64'(vif.hcount), 64'(0));
        check("post_rst_vcount", 64'(vif.vcount), 64'(0));
        check("post_rst_fs",     64'(vif.frame_start), 64'(1));

        // Randomized mode changes and occasional resets against the reference.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 199) == 0) vif.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1999) == 0) begin
                rst = 1'b0;
                repeat ($urandom_range(1, 3)) step();
                rst = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
